// File: rtl/hangman_pkg.sv
// Shared constants for the hangman game: digit width, switch count, FSM encodings.
package hangman_pkg;

  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned N_SW        = 16;
  localparam int unsigned GUESS_CNT_W = 4;
  localparam int unsigned STATE_W     = 2;

  localparam logic [GUESS_CNT_W-1:0] GUESS_CNT_MAX = '1;

  // Guess-entry FSM encodings
  localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] ST_VALID   = 2'd1;
  localparam logic [STATE_W-1:0] ST_RELEASE = 2'd2;

endpackage

// File: rtl/key_debounce.sv
// Synchronizes a raw key and only follows it after DB_CYCLES stable samples.
module key_debounce #(
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer; sync[1] is the usable sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], raw};
    end
  end

  // Count consecutive samples disagreeing with the stable level; any agreement restarts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync[1] == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= sync[1];
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/guess_entry.sv
// Turns a switch bank plus a bouncing submit key into one held guess per key press.
module guess_entry
  import hangman_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 50000,
  parameter int unsigned NSW       = N_SW
) (
  input  logic                   CLK,
  input  logic                   CLR,
  input  logic [NSW-1:0]         SW,
  input  logic                   start,
  input  logic                   ack,
  output logic [DIGIT_W-1:0]     press,
  output logic                   press_valid,
  output logic                   press_multi,
  output logic                   press_err,
  output logic [GUESS_CNT_W-1:0] guess_cnt
);

  logic [NSW-1:0]     sw_meta;
  logic [NSW-1:0]     sw_sync;
  logic               start_db;
  logic               start_prev;
  logic               submit_c;
  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] next_state;
  logic               capture_c;
  logic               err_c;
  logic               xfer_c;
  logic [DIGIT_W-1:0] enc_idx_c;
  logic               enc_multi_c;
  logic               sw_any_c;

  key_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_start_db (
    .clk  (CLK),
    .rst_n(CLR),
    .raw  (start),
    .level(start_db)
  );

  // Two-flop synchronizer for the switch bank
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
    end
  end

  // Delayed debounced key for single-cycle rising-edge detection
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      start_prev <= 1'b0;
    end else begin
      start_prev <= start_db;
    end
  end

  assign submit_c = start_db & ~start_prev;

  // Priority encoder: the lowest set switch index wins
  always_comb begin
    enc_idx_c = '0;
    for (int i = int'(NSW) - 1; i >= 0; i--) begin
      if (sw_sync[i]) enc_idx_c = DIGIT_W'(i);
    end
  end

  assign sw_any_c    = |sw_sync;
  assign enc_multi_c = |(sw_sync & (sw_sync - NSW'(1)));

  // FSM state register
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state and strobe decode
  always_comb begin
    next_state = state;
    capture_c  = 1'b0;
    err_c      = 1'b0;
    xfer_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (submit_c) begin
          if (sw_any_c) begin
            capture_c  = 1'b1;
            next_state = ST_VALID;
          end else begin
            err_c      = 1'b1;
            next_state = ST_RELEASE;
          end
        end
      end
      ST_VALID: begin
        if (ack) begin
          xfer_c     = 1'b1;
          next_state = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!start_db) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Registered guess outputs; press is only written on capture so it survives the transfer
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      press       <= '0;
      press_multi <= 1'b0;
      press_valid <= 1'b0;
      press_err   <= 1'b0;
      guess_cnt   <= '0;
    end else begin
      press_valid <= (next_state == ST_VALID);
      press_err   <= err_c;
      if (capture_c) begin
        press       <= enc_idx_c;
        press_multi <= enc_multi_c;
      end
      if (xfer_c && (guess_cnt != GUESS_CNT_MAX)) begin
        guess_cnt <= guess_cnt + GUESS_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_guess_entry.sv
// Scoreboard bench for guess_entry with a small debounce window.
module tb_guess_entry;

  localparam int unsigned DB = 4;

  logic        CLK;
  logic        CLR;
  logic [15:0] SW;
  logic        start;
  logic        ack;
  logic [3:0]  press;
  logic        press_valid;
  logic        press_multi;
  logic        press_err;
  logic [3:0]  guess_cnt;

  guess_entry #(
    .DB_CYCLES(DB),
    .NSW      (16)
  ) dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .SW         (SW),
    .start      (start),
    .ack        (ack),
    .press      (press),
    .press_valid(press_valid),
    .press_multi(press_multi),
    .press_err  (press_err),
    .guess_cnt  (guess_cnt)
  );

  typedef struct {
    bit       is_err;
    bit [3:0] idx;
    bit       multi;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   ack_mode = 0;   // 0: random ack delay, 1: ack held high, 2: never ack
  int   ack_wait = 0;

  bit       prev_pv;
  bit       prev_ack;
  bit       prev_err;
  int       exp_cnt;
  bit [3:0] last_idx;
  bit       last_multi;
  exp_t     e;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "watchdog timeout");
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Reference: lowest set bit isolated arithmetically, multi from population count
  function automatic exp_t model(input logic [15:0] v);
    exp_t        r;
    logic [15:0] low;
    r.is_err = (v == 16'd0);
    r.idx    = 4'd0;
    r.multi  = 1'b0;
    if (!r.is_err) begin
      low     = v & (~v + 16'd1);
      r.idx   = 4'($clog2(low));
      r.multi = ($countones(v) > 1);
    end
    return r;
  endfunction

  task automatic press_key(input logic [15:0] v, input int hold);
    SW = v;
    repeat (3) @(posedge CLK);
    #1;
    exp_q.push_back(model(v));
    start = 1'b1;
    repeat (hold) @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (16) @(posedge CLK);
    #1;
  endtask

  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    while (!press_valid && lat < 40) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    check(name, int'(press_valid), 1);
  endtask

  // Ack driver, acting just after each rising edge
  initial begin
    ack = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      if (!CLR) begin
        ack = 1'b0;
      end else if (ack_mode == 1) begin
        ack = 1'b1;
      end else if (ack_mode == 2) begin
        ack = 1'b0;
      end else if (press_valid) begin
        if (!ack) begin
          if (ack_wait == 0) ack = 1'b1;
          else ack_wait--;
        end
      end else begin
        ack      = ($urandom_range(0, 7) == 0);
        ack_wait = $urandom_range(0, 3);
      end
    end
  end

  // Monitor: pops expectations when the DUT presents a guess or an error pulse
  initial begin
    forever begin
      @(negedge CLK);
      if (!CLR) begin
        prev_pv    = 1'b0;
        prev_ack   = 1'b0;
        prev_err   = 1'b0;
        exp_cnt    = 0;
        last_idx   = 4'd0;
        last_multi = 1'b0;
      end else begin
        if (prev_err) check("err_one_cycle", int'(press_err), 0);
        if (prev_pv && prev_ack) begin
          if (exp_cnt < 15) exp_cnt++;
          check("valid_drop", int'(press_valid), 0);
          check("guess_cnt", int'(guess_cnt), exp_cnt);
          check("press_kept", int'(press), int'(last_idx));
        end else if (prev_pv) begin
          check("valid_hold", int'(press_valid), 1);
          if (press_valid) begin
            check("press_stable", int'(press), int'(last_idx));
            check("multi_stable", int'(press_multi), int'(last_multi));
          end
        end
        if (press_valid && !prev_pv) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("valid_kind_err", int'(e.is_err), 0);
            check("press", int'(press), int'(e.idx));
            check("press_multi", int'(press_multi), int'(e.multi));
            last_idx   = e.idx;
            last_multi = e.multi;
          end
        end
        if (press_err && !prev_err) begin
          if (exp_q.size() == 0) begin
            check("unexpected_err", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("err_kind", int'(e.is_err), 1);
            check("err_valid_low", int'(press_valid), 0);
            check("err_press_kept", int'(press), int'(last_idx));
            check("err_multi_kept", int'(press_multi), int'(last_multi));
            check("err_cnt", int'(guess_cnt), exp_cnt);
          end
        end
        prev_pv  = press_valid;
        prev_ack = ack;
        prev_err = press_err;
      end
    end
  end

  // Stimulus
  initial begin
    logic [15:0] v;
    int          lat;
    CLR   = 1'b0;
    SW    = 16'd0;
    start = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_press", int'(press), 0);
    check("rst_valid", int'(press_valid), 0);
    check("rst_multi", int'(press_multi), 0);
    check("rst_err", int'(press_err), 0);
    check("rst_cnt", int'(guess_cnt), 0);
    CLR = 1'b1;
    repeat (3) @(posedge CLK);
    #1;

    // Single-bit guess with ack ready at the first VALID cycle
    ack_mode = 1;
    press_key(16'h0020, 10);
    ack_mode = 0;

    // Priority and multi-flag corners, then an empty submit
    press_key(16'h8004, 10);
    press_key(16'h8000, 12);
    press_key(16'h0000, 10);

    // Random patterns
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0:       v = 16'd0;
        1:       v = 16'd1 << $urandom_range(0, 15);
        default: v = 16'($urandom);
      endcase
      press_key(v, 8 + $urandom_range(0, 6));
    end

    // Bouncing key: short runs must not debounce, the final hold yields one guess
    SW = 16'h0408;
    repeat (3) @(posedge CLK);
    #1;
    exp_q.push_back(model(16'h0408));
    for (int i = 0; i < 10; i++) begin
      start = ~start;
      repeat (2) @(posedge CLK);
      #1;
    end
    start = 1'b1;
    repeat (14) @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (16) @(posedge CLK);
    #1;

    // Switches wiggled while a guess waits unacknowledged
    ack_mode = 2;
    SW = 16'h0010;
    repeat (3) @(posedge CLK);
    #1;
    exp_q.push_back(model(16'h0010));
    start = 1'b1;
    wait_valid("hold_wait_valid", lat);
    for (int i = 0; i < 6; i++) begin
      SW = 16'($urandom) | 16'h0001;
      @(posedge CLK);
      #1;
    end
    ack_mode = 1;
    repeat (3) @(posedge CLK);
    #1;
    ack_mode = 0;
    start = 1'b0;
    repeat (16) @(posedge CLK);
    #1;

    // Ack held continuously, switches change once VALID is up
    ack_mode = 1;
    SW = 16'h0300;
    repeat (3) @(posedge CLK);
    #1;
    exp_q.push_back(model(16'h0300));
    start = 1'b1;
    wait_valid("ackhold_wait_valid", lat);
    SW = 16'h0001;
    repeat (3) @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (16) @(posedge CLK);
    #1;
    ack_mode = 0;

    // Reset mid-VALID with the key held through reset release
    ack_mode = 2;
    SW = 16'h0040;
    repeat (3) @(posedge CLK);
    #1;
    exp_q.push_back(model(16'h0040));
    start = 1'b1;
    wait_valid("rst_pre_valid", lat);
    repeat (2) @(posedge CLK);
    #2;
    CLR = 1'b0;
    #1;
    check("midrst_press", int'(press), 0);
    check("midrst_valid", int'(press_valid), 0);
    check("midrst_multi", int'(press_multi), 0);
    check("midrst_err", int'(press_err), 0);
    check("midrst_cnt", int'(guess_cnt), 0);
    ack_mode = 1;
    repeat (2) @(posedge CLK);
    #3;
    CLR = 1'b1;
    exp_q.push_back(model(16'h0040));
    lat = 0;
    while (!press_valid && lat < 40) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    check("rst_hold_latency", lat, 2 + int'(DB) + 1);
    repeat (3) @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (16) @(posedge CLK);
    #1;
    ack_mode = 0;

    // Twenty more acknowledged guesses saturate the counter
    for (int i = 0; i < 20; i++) begin
      v = 16'($urandom) | (16'd1 << $urandom_range(0, 15));
      press_key(v, 8 + $urandom_range(0, 4));
    end
    check("guess_cnt_sat", int'(guess_cnt), 15);

    repeat (10) @(posedge CLK);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/guess_entry.md
GUESS_ENTRY -- requirements
Module: guess_entry

Interface
REQ-001 Parameter DB_CYCLES, default 50000, number of consecutive stable synchronized samples before the start key level is accepted.
REQ-002 Parameter NSW, default 16, switch count; press width is fixed at 4.
REQ-003 CLK  input  1  single system clock; all state changes on posedge CLK.
REQ-004 CLR  input  1  reset, asynchronous, active-low.
REQ-005 SW  input  NSW  raw guess switches, asynchronous to CLK.
REQ-006 start  input  1  raw submit key, active-high, bouncing, asynchronous.
REQ-007 ack  input  1  consumer (game FSM) accepts the current guess.
REQ-008 press  output  4  guessed value, index of the selected switch.
REQ-009 press_valid  output  1  guess available; held until accepted.
REQ-010 press_multi  output  1  more than one switch was set at capture.
REQ-011 press_err  output  1  one-cycle pulse: submit with no switch set.
REQ-012 guess_cnt  output  4  number of accepted guesses since reset.

Function
REQ-013 SW and start SHALL each pass through a 2-flop synchronizer before use.
REQ-014 start_db SHALL change to the synchronized level only after DB_CYCLES consecutive equal samples differing from the current start_db; any mismatch restarts the count.
REQ-015 A submit event SHALL be a 0->1 transition of start_db, detected in a single cycle.
REQ-016 FSM states SHALL be IDLE, VALID, RELEASE.
REQ-017 IDLE: on submit with synchronized SW nonzero, capture press = lowest set index (SW[0] highest priority), press_multi = 1 if more than one bit is set, else 0; go to VALID; press_valid is high the cycle after the submit cycle.
REQ-018 IDLE: on submit with SW all zero, pulse press_err for exactly one cycle, leave press/press_multi unchanged, go to RELEASE.
REQ-019 VALID: press_valid = 1; press and press_multi held stable; transfer occurs on a cycle with press_valid && ack; the following cycle press_valid = 0, guess_cnt increments, state goes to RELEASE.
REQ-020 ack while press_valid = 0 SHALL be ignored; ack held high in advance SHALL complete the transfer in the first VALID cycle.
REQ-021 Switch changes while in VALID SHALL NOT alter press.
REQ-022 RELEASE: wait until start_db = 0, then go to IDLE; no new submit is possible until then, so a held key yields exactly one guess.
REQ-023 guess_cnt SHALL saturate at 15, not wrap.
REQ-024 press SHALL retain the last captured value after the transfer.

Reset
REQ-025 CLR low SHALL asynchronously force: state IDLE, press 0, press_valid 0, press_multi 0, press_err 0, guess_cnt 0, start_db 0, debounce counter 0, and synchronizer flops 0.
REQ-026 Reset asserted mid-VALID SHALL drop press_valid immediately without counting a transfer.
REQ-027 If start is held through reset release, exactly one submit SHALL occur after DB_CYCLES + synchronizer latency.

Structure
REQ-028 Shared package hangman_pkg SHALL hold the FSM state encodings, the 4-bit digit width constant, and the switch count constant, so they are shared with the game FSM.
REQ-029 The debounce logic (synchronizer, counter, and stable level) SHALL be one sub-module, key_debounce, instantiated once for start; the switch priority encoder stays inline.

Verification (DB_CYCLES = 4)
REQ-030 SW = 16'h0020, clean start press -> press = 5, press_multi = 0, press_valid rises once; ack at the first VALID cycle -> guess_cnt = 1, press_valid low next cycle.
REQ-031 SW = 16'h8004 -> press = 2, press_multi = 1; SW = 16'h8000 -> press = 15, press_multi = 0.
REQ-032 SW = 0, submit -> press_err high exactly 1 cycle, press_valid stays 0, guess_cnt unchanged.
REQ-033 start toggled every 2 cycles for 20 cycles, then held high -> exactly one press_valid assertion; 20 ack'd submits -> guess_cnt = 15.
REQ-034 CLR pulled low while press_valid = 1 and ack = 0 -> all outputs 0 in the same cycle; start held through CLR release -> one new guess after debounce.
REQ-035 ack held high continuously; SW changed during VALID -> transfer in the first VALID cycle with the originally captured press.
